// File: rtl/gate_checker_pkg.sv
// Shared definitions for the gate checker: FSM state encodings, vector count,
// default settle time and the per-vector compare helper.
package gate_checker_pkg;

    localparam int N_VECTORS         = 8;
    localparam int SETTLE_CYCLES_DEF = 4;
    localparam int IDX_W             = 3;
    localparam int CNT_W             = 4;
    localparam int ERR_W             = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    function automatic logic vec_mismatch(
        input logic             s1,
        input logic             s2,
        input logic [7:0]       exp_s1,
        input logic [7:0]       exp_s2,
        input logic [IDX_W-1:0] idx
    );
        return (s1 != exp_s1[idx]) || (s2 != exp_s2[idx]);
    endfunction

endpackage

// File: rtl/gate_checker_if.sv
// Bundle between the gate checker (slave) and its environment (master): run control,
// expected truth table, DUT stimulus/response and result reporting.
interface gate_checker_if;
    logic       start;
    logic [7:0] exp_s1;
    logic [7:0] exp_s2;
    logic       s1;
    logic       s2;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic       fail_valid;
    logic [2:0] first_fail_idx;

    modport slave (
        input  start, exp_s1, exp_s2, s1, s2,
        output a, b, c, busy, done, pass, err_count, fail_valid, first_fail_idx
    );

    modport master (
        output start, exp_s1, exp_s2, s1, s2,
        input  a, b, c, busy, done, pass, err_count, fail_valid, first_fail_idx
    );
endinterface

// File: rtl/gate_checker_settle_timer.sv
// Settle timer: clears on load, counts while enabled, flags terminal count at i_limit.
module settle_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_limit,
    output logic             o_tc
);

    logic [WIDTH-1:0] r_count;

    // Counter register: load wins over count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            r_count <= r_count;
        end
    end

    assign o_tc = (r_count == i_limit);

endmodule

// File: rtl/gate_checker.sv
// Exhaustive tester for a 3-input, 2-output combinational DUT: steps {a,b,c} through
// all 8 vectors, lets each settle, samples s1/s2 and records mismatches.
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic      clk,
    input  logic      rst_n,
    gate_checker_if.slave bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [2:0]       r_abc;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [ERR_W-1:0] r_err;
    logic             r_fail_valid;
    logic [IDX_W-1:0] r_first_fail;

    logic             w_accept;
    logic             w_tmr_load;
    logic             w_tmr_en;
    logic             w_tc;
    logic             w_mismatch;
    logic [ERR_W-1:0] w_err_next;

    assign w_accept   = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && bus.start;
    // Sampling also rearms the timer so the next vector starts from zero.
    assign w_tmr_load = w_accept || (r_state == ST_SAMPLE);
    assign w_tmr_en   = (r_state == ST_SETTLE) && !w_tc;
    assign w_mismatch = vec_mismatch(bus.s1, bus.s2, bus.exp_s1, bus.exp_s2, r_idx);
    assign w_err_next = r_err + {{(ERR_W-1){1'b0}}, w_mismatch};

    settle_timer #(.WIDTH(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_tmr_load),
        .i_en    (w_tmr_en),
        .i_limit (LIMIT),
        .o_tc    (w_tc)
    );

    // Run FSM with all reported outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_idx        <= 3'd0;
            r_abc        <= 3'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_err        <= 4'd0;
            r_fail_valid <= 1'b0;
            r_first_fail <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (bus.start) begin
                        r_state      <= ST_SETTLE;
                        r_idx        <= 3'd0;
                        r_abc        <= 3'd0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_err        <= 4'd0;
                        r_fail_valid <= 1'b0;
                        r_first_fail <= 3'd0;
                    end else begin
                        r_state <= r_state;
                    end
                end
                ST_SETTLE: begin
                    if (w_tc) begin
                        r_state <= ST_SAMPLE;
                    end else begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SAMPLE: begin
                    r_err <= w_err_next;
                    if (w_mismatch && !r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_first_fail <= r_idx;
                    end else begin
                        r_fail_valid <= r_fail_valid;
                    end
                    if (r_idx == 3'd7) begin
                        r_state <= ST_DONE;
                        r_abc   <= 3'd0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 4'd0);
                    end else begin
                        r_state <= ST_SETTLE;
                        r_idx   <= r_idx + 3'd1;
                        r_abc   <= r_idx + 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_abc   <= 3'd0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.a              = r_abc[2];
    assign bus.b              = r_abc[1];
    assign bus.c              = r_abc[0];
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_pass;
    assign bus.err_count      = r_err;
    assign bus.fail_valid     = r_fail_valid;
    assign bus.first_fail_idx = r_first_fail;

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker: two instances (settle 4 and 1) drive a modelled
// gate DUT with selectable faults; a monitor checks each completed run against a queue.
module tb_gate_checker;

    typedef struct {
        int   err;
        logic fv;
        int   ffi;
        logic pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   fault = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    gate_checker_if if0();
    gate_checker_if if1();

    gate_checker #(.SETTLE_CYCLES(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    gate_checker #(.SETTLE_CYCLES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Gate model S1=A&B, S2=~C; fault 1 sticks s1 at 0, fault 2 inverts s2.
    assign if0.s1 = (fault == 1) ? 1'b0 : (if0.a & if0.b);
    assign if0.s2 = (fault == 2) ? if0.c : ~if0.c;
    assign if1.s1 = if1.a & if1.b;
    assign if1.s2 = ~if1.c;

    logic       busy_v [2];
    logic       done_v [2];
    logic       pass_v [2];
    logic       fv_v   [2];
    logic [3:0] err_v  [2];
    logic [2:0] ffi_v  [2];
    logic [2:0] abc_v  [2];

    assign busy_v[0] = if0.busy;            assign busy_v[1] = if1.busy;
    assign done_v[0] = if0.done;            assign done_v[1] = if1.done;
    assign pass_v[0] = if0.pass;            assign pass_v[1] = if1.pass;
    assign fv_v[0]   = if0.fail_valid;      assign fv_v[1]   = if1.fail_valid;
    assign err_v[0]  = if0.err_count;       assign err_v[1]  = if1.err_count;
    assign ffi_v[0]  = if0.first_fail_idx;  assign ffi_v[1]  = if1.first_fail_idx;
    assign abc_v[0]  = {if0.a, if0.b, if0.c};
    assign abc_v[1]  = {if1.a, if1.b, if1.c};

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: tracks {a,b,c} stepping while busy and scores each rising done.
    task automatic monitor(input int k, input int per);
        int   cyc = 0;
        logic pb = 1'b0;
        logic pd = 1'b0;
        logic abc_ok = 1'b1;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy_v[k] && !pb) begin
                cyc = 0;
                abc_ok = 1'b1;
            end
            if (busy_v[k]) begin
                if (abc_v[k] != 3'(cyc / per)) abc_ok = 1'b0;
                cyc++;
            end
            if (done_v[k] && !pd) begin
                if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
                    checks++;
                    errors++;
                    $display("FAIL u%0d_unexpected_done: got a completed run, expected none", k);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("u%0d_err_count", k), int'(err_v[k]), e.err);
                    chk($sformatf("u%0d_fail_valid", k), int'(fv_v[k]), int'(e.fv));
                    chk($sformatf("u%0d_first_fail_idx", k), int'(ffi_v[k]), e.ffi);
                    chk($sformatf("u%0d_pass", k), int'(pass_v[k]), int'(e.pass));
                    chk($sformatf("u%0d_run_cycles", k), cyc, 8 * per);
                    chk($sformatf("u%0d_abc_sequence", k), int'(abc_ok), 1);
                    chk($sformatf("u%0d_abc_in_done", k), int'(abc_v[k]), 0);
                end
            end
            pb = busy_v[k];
            pd = done_v[k];
        end
    endtask

    initial monitor(0, 5);
    initial monitor(1, 2);

    task automatic push0(input int err, input logic fv, input int ffi, input logic pass);
        exp_t e;
        e.err = err; e.fv = fv; e.ffi = ffi; e.pass = pass;
        q0.push_back(e);
    endtask

    task automatic wait_done(input int k, input int budget);
        int n = 0;
        while (!done_v[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done_v[k]) begin
            checks++;
            errors++;
            $display("FAIL u%0d_done_timeout: done still 0 after %0d cycles, expected 1", k, budget);
        end
    endtask

    task automatic check_idle0(input string tag);
        chk({tag, "_busy"}, int'(if0.busy), 0);
        chk({tag, "_done"}, int'(if0.done), 0);
        chk({tag, "_pass"}, int'(if0.pass), 0);
        chk({tag, "_fail_valid"}, int'(if0.fail_valid), 0);
        chk({tag, "_err_count"}, int'(if0.err_count), 0);
        chk({tag, "_first_fail_idx"}, int'(if0.first_fail_idx), 0);
        chk({tag, "_abc"}, int'({if0.a, if0.b, if0.c}), 0);
    endtask

    task automatic pulse0();
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        int   n;
        if0.start = 1'b0; if0.exp_s1 = 8'hC0; if0.exp_s2 = 8'h55;
        if1.start = 1'b0; if1.exp_s1 = 8'hC0; if1.exp_s2 = 8'h55;

        #12;
        check_idle0("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_after_reset_busy", int'(if0.busy), 0);

        // Good DUT
        push0(0, 1'b0, 0, 1'b1);
        pulse0();
        wait_done(0, 100);

        // s1 stuck at 0: vectors 6 and 7 fail
        fault = 1;
        push0(2, 1'b1, 6, 1'b0);
        pulse0();
        wait_done(0, 100);

        // Restart from DONE: results clear on the accept edge, then repeat
        push0(2, 1'b1, 6, 1'b0);
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        chk("restart_err_cleared", int'(if0.err_count), 0);
        chk("restart_fv_cleared", int'(if0.fail_valid), 0);
        chk("restart_done_low", int'(if0.done), 0);
        chk("restart_busy_high", int'(if0.busy), 1);
        wait_done(0, 100);

        // s2 inverted: every vector fails
        fault = 2;
        push0(8, 1'b1, 0, 1'b0);
        pulse0();
        wait_done(0, 100);

        // start held high for the whole run: one run only
        fault = 0;
        push0(0, 1'b0, 0, 1'b1);
        @(negedge clk);
        if0.start = 1'b1;
        @(negedge clk);
        wait_done(0, 100);
        if0.start = 1'b0;
        repeat (60) @(negedge clk);
        chk("held_start_done_stays", int'(if0.done), 1);
        chk("held_start_no_rerun", int'(if0.busy), 0);
        chk("held_start_queue_empty", q0.size(), 0);

        // Short settle instance
        e.err = 0; e.fv = 1'b0; e.ffi = 0; e.pass = 1'b1;
        q1.push_back(e);
        @(negedge clk);
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        wait_done(1, 50);

        // Reset in the middle of a run while vector 3 is applied
        fault = 1;
        pulse0();
        n = 0;
        while ({if0.a, if0.b, if0.c} != 3'd3 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("midrun_reached_idx3", int'({if0.a, if0.b, if0.c}), 3);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle0("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_reset_stays_idle", int'(if0.busy), 0);
        chk("post_reset_no_done", int'(if0.done), 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", q0.size() + q1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gate_checker.md
GATE_CHECKER -- requirements
Module: gate_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4: clock cycles each input vector is held before the DUT outputs are sampled; legal range 1..15.
REQ-002 clk  input  1  rising-edge clock; the only clock in the block.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  run request; sampled only in IDLE or DONE.
REQ-005 exp_s1  input  8  expected S1 output; bit i is the value for vector i.
REQ-006 exp_s2  input  8  expected S2 output; bit i is the value for vector i.
REQ-007 s1, s2  input  1 each  outputs returned by the combinational DUT under test.
REQ-008 a, b, c  output  1 each  DUT stimulus; {a,b,c} = vector index, with a as the MSB.
REQ-009 busy  output  1  high while a run is in progress.
REQ-010 done  output  1  high while in DONE.
REQ-011 pass  output  1  high in DONE when err_count is 0.
REQ-012 err_count  output  4  number of mismatching vectors in the current run (0..8).
REQ-013 fail_valid  output  1  high once a mismatch has been recorded in the current run.
REQ-014 first_fail_idx  output  3  index of the first mismatching vector; valid only while fail_valid is high.

Function
REQ-015 FSM states: IDLE, SETTLE, SAMPLE, DONE.
REQ-016 IDLE or DONE with start=1 at an edge: idx<=0, settle counter<=0, err_count<=0, fail_valid<=0, first_fail_idx<=0; next state is SETTLE.
REQ-017 SETTLE: the counter increments each cycle; when it reaches SETTLE_CYCLES-1, the next state is SAMPLE.
REQ-018 SAMPLE (one cycle): a mismatch is s1!=exp_s1[idx] or s2!=exp_s2[idx].
- On a mismatch, err_count increments.
- On the first mismatch of a run, first_fail_idx<=idx and fail_valid<=1.
REQ-019 SAMPLE exit: if idx==7, the next state is DONE; otherwise idx increments, the counter clears, and the next state is SETTLE.
REQ-020 Each vector occupies exactly SETTLE_CYCLES+1 cycles; done rises 8*(SETTLE_CYCLES+1) cycles after the start-accept edge.
REQ-021 a, b, c are registered from idx, are stable throughout SETTLE and SAMPLE, and return to 000 in IDLE and DONE.
REQ-022 start is ignored in SETTLE and SAMPLE.
REQ-023 DONE holds done, pass, err_count, fail_valid and first_fail_idx until the next accepted start.
REQ-024 busy = state is SETTLE or SAMPLE; pass = done and err_count==0.
REQ-025 idx never wraps: SAMPLE with idx==7 always goes to DONE.
REQ-026 err_count never exceeds 8, so no saturation is required.

Reset
REQ-027 While rst_n is low, regardless of clk, the block is in IDLE with:
- a, b, c, busy, done, pass, fail_valid = 0;
- err_count = 0, first_fail_idx = 0;
- idx and the settle counter = 0.
REQ-028 Reset asserted mid-run abandons the run immediately; no partial result is retained.
REQ-029 After reset deasserts, the block stays in IDLE until a start is accepted.

Structure
REQ-030 Shared include file gate_checker_defs.v contains:
- the state encodings;
- N_VECTORS=8;
- the default SETTLE_CYCLES.
REQ-031 One sub-module, settle_timer, is natural: a load/count/terminal-count counter, width 4.
REQ-032 All state is registered in the clk domain; the comparison logic is combinational and feeds the SAMPLE-state registers.

Verification
REQ-033 Good DUT model (S1=A&B, S2=~C), exp_s1=8'hC0, exp_s2=8'h55, SETTLE_CYCLES=4, one-cycle start pulse:
- {a,b,c} steps 000..111;
- done rises 40 cycles after the accept edge;
- pass=1, err_count=0, fail_valid=0.
REQ-034 Same setup with s1 stuck at 0 -> err_count=2, fail_valid=1, first_fail_idx=6, pass=0.
REQ-035 Same setup with s2 inverted -> err_count=8, first_fail_idx=0.
REQ-036 start held high for the whole run -> exactly one run completes.
REQ-037 New start pulse while in DONE -> err_count and fail_valid clear on the next edge and the run repeats with identical results.
REQ-038 rst_n pulsed low while idx==3 -> all outputs read 0 at once; the block remains in IDLE until a new start.
REQ-039 SETTLE_CYCLES=1 with the good DUT -> done after 16 cycles, pass=1.
